alu_cmd_issuer: RTL and testbench
=================================

// Module: alu_cmd_issuer
// PURPOSE
// - Upstream feeder for the sequential ALU. Buffers {opcode,A,B} commands in a FIFO and issues
//   them one at a time on the ALU en/opcode/A/B inputs.
// - Captures ALU result C one cycle after issue and presents it, with its opcode, on a
//   valid/ready result port.
// - Sits between the command source (testbench/sequencer) and the ALU; the ALU stays unchanged.
// PARAMETERS
// - WIDTH  8  operand/result width; must equal the ALU A/B/C width
// - DEPTH  4  command FIFO entries; power of 2, >= 2
// - TAG_W  4  sequence-tag width; used only when ALU_ISSUER_TAG_EN is defined
// PORTS
// - clk         in   1                    single clock; all logic on posedge
// - rst         in   1                    synchronous reset, active-high
// - in_valid    in   1                    command present
// - in_ready    out  1                    = !fifo_full; accept on in_valid && in_ready
// - in_opcode   in   2                    package enum: ADD, SUB, AND, OR
// - in_a        in   WIDTH                operand A
// - in_b        in   WIDTH                operand B
// - alu_en      out  1                    to ALU en; one-cycle pulse per command
// - alu_opcode  out  2                    to ALU opcode
// - alu_a       out  WIDTH                to ALU A
// - alu_b       out  WIDTH                to ALU B
// - alu_c       in   WIDTH                from ALU C
// - res_valid   out  1                    result held in res_data/res_opcode
// - res_ready   in   1                    result consumed on res_valid && res_ready
// - res_data    out  WIDTH                captured ALU result
// - res_opcode  out  2                    opcode that produced res_data
// - fifo_count  out  $clog2(DEPTH+1)      FIFO occupancy, 0..DEPTH
// - busy        out  1                    state != IDLE || fifo_count != 0 || res_valid
// BEHAVIOUR
// - Reset (rst=1 at posedge):
//   - state=IDLE; FIFO pointers and fifo_count = 0.
//   - alu_en, alu_opcode, alu_a, alu_b, res_valid, res_data and res_opcode = 0.
//   - A reset mid-operation drops all queued, in-flight and held results. No partial output.
// - FIFO:
//   - Push on in_valid && in_ready. Pop only in IDLE when issuing.
//   - A push and a pop in the same cycle leave fifo_count unchanged.
//   - When full, in_ready=0 and in_valid is ignored. Pointers wrap modulo DEPTH.
//   - No bypass: a command pushed at edge N is first issuable at edge N+1.
// - FSM: IDLE -> ISSUE -> CAPTURE -> IDLE.
//   - IDLE: issue when fifo_count != 0 && (!res_valid || res_ready).
//     On issue: register the FIFO head onto alu_opcode/alu_a/alu_b, set alu_en<=1, pop, go to ISSUE.
//     Otherwise hold, with alu_en=0.
//   - ISSUE: alu_en is visible for exactly this cycle. Set alu_en<=0 and go to CAPTURE.
//     alu_opcode/alu_a/alu_b hold until the next issue.
//   - CAPTURE: alu_c now reflects the command. Set res_data<=alu_c, res_opcode<=alu_opcode,
//     res_valid<=1, then go to IDLE.
// - Result port:
//   - res_valid drops on the edge where res_valid && res_ready, unless a new capture happens on
//     that same edge.
//   - res_data and res_opcode stay stable while res_valid && !res_ready.
//   - The issue gate guarantees the result slot is free at CAPTURE. No result is ever overwritten.
// - Latency and throughput:
//   - Idle push at edge N gives alu_en high from N+1 to N+2 and res_valid high from edge N+3.
//   - Peak throughput is 1 command per 3 cycles.
// - Arithmetic is done entirely in the ALU; this block never modifies data. Widths are passed through.
// CONFIGURATION
// - ALU_ISSUER_TAG_EN defined:
//   - Adds output res_tag [TAG_W-1:0] and an issue counter.
//   - The counter resets to 0 and increments on each issue, wrapping at 2**TAG_W.
//   - At CAPTURE, res_tag takes the counter value used at that command's issue.
//     The first result after reset has tag 0.
// - ALU_ISSUER_TAG_EN undefined:
//   - No res_tag port and no counter. All other behaviour is identical.
// TESTING
// - Reset then idle -> in_ready=1, fifo_count=0, alu_en=0, res_valid=0, busy=0.
// - Push ADD A=8'h05 B=8'h03, res_ready=1 -> one alu_en pulse; res_valid 3 edges later;
//   res_data=8'h08, res_opcode=ADD.
// - res_ready=0; push SUB 8'h02-8'h03, then OR 8'hF0|8'h0F -> first res_data=8'hFF (SUB) held;
//   no second alu_en until res_ready=1; then res_data=8'hFF (OR).
// - Push DEPTH+1 commands with res_ready=0 -> in_ready=0 once fifo_count=DEPTH;
//   the extra command is dropped and results arrive in FIFO order.
// - Assert rst during ISSUE with 2 entries queued -> next cycle fifo_count=0, res_valid=0,
//   alu_en=0; no result appears afterwards.
// - With ALU_ISSUER_TAG_EN and TAG_W=2, issue 5 AND commands -> res_tag sequence 0,1,2,3,0.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Command FIFO and issue sequencer in front of the sequential ALU: issues one {opcode,A,B} at a time
// and holds each captured result on a valid/ready port. Optional result tagging: ALU_ISSUER_TAG_EN.
module alu_cmd_issuer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_opcode,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic                       alu_en,
    output logic [1:0]                 alu_opcode,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    input  logic [WIDTH-1:0]           alu_c,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           res_data,
    output logic [1:0]                 res_opcode,
`ifdef ALU_ISSUER_TAG_EN
    output logic [TAG_W-1:0]           res_tag,
`endif
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       busy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       opc_mem [DEPTH];
    logic [WIDTH-1:0] a_mem   [DEPTH];
    logic [WIDTH-1:0] b_mem   [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, issue;

    assign in_ready = (fifo_count != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign busy     = (state != IDLE) || (fifo_count != '0) || res_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Issue only when the result slot is free or being drained this edge, so CAPTURE never overwrites.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if ((fifo_count != '0) && (!res_valid || res_ready)) begin
                    issue     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Storage carries no reset; occupancy is tracked by the pointers and count only.
    always_ff @(posedge clk) begin
        if (push) begin
            opc_mem[wr_ptr] <= in_opcode;
            a_mem[wr_ptr]   <= in_a;
            b_mem[wr_ptr]   <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            alu_en     <= 1'b0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_opcode <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (issue) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, issue})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase

            alu_en <= issue;
            if (issue) begin
                alu_opcode <= opc_mem[rd_ptr];
                alu_a      <= a_mem[rd_ptr];
                alu_b      <= b_mem[rd_ptr];
            end

            if (state == CAPTURE) begin
                res_data   <= alu_c;
                res_opcode <= alu_opcode;
                res_valid  <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid  <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUER_TAG_EN
    logic [TAG_W-1:0] issue_cnt, issue_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt <= '0;
            issue_tag <= '0;
            res_tag   <= '0;
        end else begin
            if (issue) begin
                issue_tag <= issue_cnt;
                issue_cnt <= issue_cnt + TAG_W'(1);
            end
            if (state == CAPTURE) res_tag <= issue_tag;
        end
    end
`else
    logic tag_w_unused;
    assign tag_w_unused = |TAG_W;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural sequential ALU hooked to its ALU port.
// Define ALU_ISSUER_TAG_EN on both files to also exercise result tagging.
module tb_alu_cmd_issuer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int TAG_W = 2;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_opcode = '0;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             alu_en;
    logic [1:0]       alu_opcode;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [WIDTH-1:0] alu_c = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_data;
    logic [1:0]       res_opcode;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic             busy;
`ifdef ALU_ISSUER_TAG_EN
    logic [TAG_W-1:0] res_tag;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int en_cnt = 0;

    alu_cmd_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
        .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_opcode(res_opcode),
`ifdef ALU_ISSUER_TAG_EN
        .res_tag(res_tag),
`endif
        .fifo_count(fifo_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Sequential ALU: result appears on C one edge after en.
    always @(posedge clk) begin
        if (alu_en) begin
            case (alu_opcode)
                OP_ADD:  alu_c <= alu_a + alu_b;
                OP_SUB:  alu_c <= alu_a - alu_b;
                OP_AND:  alu_c <= alu_a & alu_b;
                default: alu_c <= alu_a | alu_b;
            endcase
        end
    end

    always @(posedge clk) if (alu_en) en_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic wait_res(input int maxc);
        int n = 0;
        while (!res_valid && n < maxc) begin
            tick();
            n++;
        end
        chk("res_arrived", 32'(res_valid), 32'd1);
    endtask

    logic [1:0]       exp_op [5];
    logic [WIDTH-1:0] exp_d  [5];
    int en_base;
    int seen;

    initial begin
        // Reset and idle
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_alu_en", 32'(alu_en), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);

        // Single ADD, exact latency
        res_ready = 1'b1;
        push(OP_ADD, 8'h05, 8'h03);
        chk("add_count_n", 32'(fifo_count), 32'd1);
        chk("add_en_n", 32'(alu_en), 32'd0);
        tick();
        chk("add_en_n1", 32'(alu_en), 32'd1);
        chk("add_alu_a", 32'(alu_a), 32'h05);
        chk("add_alu_b", 32'(alu_b), 32'h03);
        chk("add_count_n1", 32'(fifo_count), 32'd0);
        tick();
        chk("add_en_n2", 32'(alu_en), 32'd0);
        chk("add_rv_n2", 32'(res_valid), 32'd0);
        tick();
        chk("add_rv_n3", 32'(res_valid), 32'd1);
        chk("add_data", 32'(res_data), 32'h08);
        chk("add_op", 32'(res_opcode), 32'(OP_ADD));
        tick();
        chk("add_rv_drop", 32'(res_valid), 32'd0);
        chk("add_busy", 32'(busy), 32'd0);

        // Backpressure: SUB held, OR blocked until ready
        res_ready = 1'b0;
        push(OP_SUB, 8'h02, 8'h03);
        push(OP_OR, 8'hF0, 8'h0F);
        wait_res(10);
        chk("sub_data", 32'(res_data), 32'hFF);
        chk("sub_op", 32'(res_opcode), 32'(OP_SUB));
        en_base = en_cnt;
        repeat (5) tick();
        chk("sub_held_rv", 32'(res_valid), 32'd1);
        chk("sub_held_data", 32'(res_data), 32'hFF);
        chk("sub_held_op", 32'(res_opcode), 32'(OP_SUB));
        chk("blocked_no_en", 32'(en_cnt - en_base), 32'd0);
        chk("blocked_count", 32'(fifo_count), 32'd1);
        res_ready = 1'b1;
        tick();
        chk("sub_drop", 32'(res_valid), 32'd0);
        chk("or_issue_en", 32'(alu_en), 32'd1);
        chk("or_issue_op", 32'(alu_opcode), 32'(OP_OR));
        wait_res(10);
        chk("or_data", 32'(res_data), 32'hFF);
        chk("or_op", 32'(res_opcode), 32'(OP_OR));
        tick();
        chk("or_drop", 32'(res_valid), 32'd0);

        // Overflow: hold a result, then push DEPTH+1 commands
        res_ready = 1'b0;
        exp_op[0] = OP_ADD; exp_d[0] = 8'h0B;
        exp_op[1] = OP_SUB; exp_d[1] = 8'h0F;
        exp_op[2] = OP_AND; exp_d[2] = 8'h30;
        exp_op[3] = OP_OR;  exp_d[3] = 8'hC3;
        exp_op[4] = OP_ADD; exp_d[4] = 8'h01;
        push(OP_ADD, 8'h0A, 8'h01);
        wait_res(10);
        en_base = en_cnt;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            case (i)
                1: begin in_opcode = OP_SUB; in_a = 8'h10; in_b = 8'h01; end
                2: begin in_opcode = OP_AND; in_a = 8'hF0; in_b = 8'h3C; end
                3: begin in_opcode = OP_OR;  in_a = 8'h81; in_b = 8'h42; end
                4: begin in_opcode = OP_ADD; in_a = 8'hFF; in_b = 8'h02; end
                default: begin in_opcode = OP_ADD; in_a = 8'h55; in_b = 8'h55; end
            endcase
            chk($sformatf("fill_ready_%0d", i), 32'(in_ready), (i < 5) ? 32'd1 : 32'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_res(12);
            chk($sformatf("ord_data_%0d", k), 32'(res_data), 32'(exp_d[k]));
            chk($sformatf("ord_op_%0d", k), 32'(res_opcode), 32'(exp_op[k]));
            tick();
        end
        repeat (8) tick();
        chk("drain_count", 32'(fifo_count), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_en_pulses", 32'(en_cnt - en_base), 32'd4);

        // Reset during ISSUE with two entries queued
        res_ready = 1'b0;
        push(OP_ADD, 8'h01, 8'h01);
        wait_res(10);
        push(OP_ADD, 8'h11, 8'h01);
        push(OP_SUB, 8'h22, 8'h01);
        push(OP_OR, 8'h33, 8'h01);
        res_ready = 1'b1;
        tick();
        chk("pre_rst_count", 32'(fifo_count), 32'd2);
        chk("pre_rst_en", 32'(alu_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_rv", 32'(res_valid), 32'd0);
        chk("mid_rst_en", 32'(alu_en), 32'd0);
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rst_data", 32'(res_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        en_base = en_cnt;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_valid) seen++;
        end
        chk("post_rst_no_res", 32'(seen), 32'd0);
        chk("post_rst_no_en", 32'(en_cnt - en_base), 32'd0);

`ifdef ALU_ISSUER_TAG_EN
        // Tag sequence wraps at 2**TAG_W
        for (int i = 0; i < 5; i++) begin
            push(OP_AND, 8'hFF, 8'(i * 3 + 1));
            wait_res(10);
            chk($sformatf("tag_data_%0d", i), 32'(res_data), 32'(i * 3 + 1));
            chk($sformatf("tag_%0d", i), 32'(res_tag), 32'(i % 4));
            tick();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
